pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The parameter REG_ID_W SHALL default to 6 and set the register-id width; the scoreboard SHALL hold 2**REG_ID_W entries, covering the integer and FP register files.
REQ-002 The parameter DRAIN_CYCLES SHALL default to 3 and set the number of bubble cycles inserted before HALTED.
REQ-003 The parameter CNT_W SHALL default to 32 and set the width of the performance counters.
REQ-004 clk_i  in  1  the block's only clock.
REQ-005 reset_i  in  1  reset, synchronous and active-high.
REQ-006 halt_i  in  1  halt request from execute (EBREAK/HALT).
REQ-007 aluBusy_i  in  1  multi-cycle ALU/FPU op occupies E.
REQ-008 E_correctPC_i  in  1  branch/jump mispredict resolved in E.
REQ-009 D_valid_i  in  1  D holds a real instruction, not a nop.
REQ-010 D_rs1Id_i, D_rs2Id_i, D_rs3Id_i  in  REG_ID_W each  source ids in D.
REQ-011 D_rsUse_i  in  3  bit n set means rs(n+1) is read.
REQ-012 D_rdId_i  in  REG_ID_W  destination id in D.
REQ-013 D_wbEnable_i  in  1  D instruction writes rd.
REQ-014 D_longLat_i  in  1  D result is not forwardable from E (load, AMO, DIV, FPU).
REQ-015 MW_wbEnable_i  in  1  writeback valid this cycle.
REQ-016 MW_rdId_i  in  REG_ID_W  writeback destination.
REQ-017 F_stall_o, D_stall_o, E_stall_o, D_flush_o, E_flush_o, M_flush_o  out  1 each  pipeline controls.
REQ-018 dataHazard_o  out  1  RAW hazard detected in D.
REQ-019 halted_o  out  1  pipeline drained and halted.
REQ-020 stallCycles_o, flushCount_o  out  CNT_W each  performance counters.

Function
REQ-021 The scoreboard SHALL hold 1 pending bit per register id; id 0 SHALL never be set.
REQ-022 issue SHALL be D_valid_i & D_wbEnable_i & D_longLat_i & (D_rdId_i != 0) & !D_stall_o & !D_flush_o & (state == RUN).
REQ-023 On a clock edge with issue, the bit at D_rdId_i SHALL be set.
REQ-024 On a clock edge with MW_wbEnable_i, the bit at MW_rdId_i SHALL be cleared.
REQ-025 When a set and a clear target the same id on the same edge, set SHALL win.
REQ-026 dataHazard_o SHALL be D_valid_i & OR over used rs(n) of (pend[rs(n)] & !(MW_wbEnable_i & MW_rdId_i == rs(n))); this is combinational, and same-cycle writeback bypasses the hazard.
REQ-027 E_stall_o SHALL be aluBusy_i.
REQ-028 M_flush_o SHALL be aluBusy_i.
REQ-029 E_correctPC_i SHALL be ignored while aluBusy_i is high.
REQ-030 D_flush_o SHALL be E_correctPC_i & !aluBusy_i.
REQ-031 F_stall_o and D_stall_o SHALL each be (dataHazard_o | aluBusy_i | state != RUN) & !D_flush_o.
REQ-032 E_flush_o SHALL be !aluBusy_i & (D_flush_o | dataHazard_o | state == DRAIN).
REQ-033 The FSM SHALL be RUN -> DRAIN on halt_i; DRAIN -> HALTED after DRAIN_CYCLES cycles with !aluBusy_i; HALTED is sticky until reset.
REQ-034 The drain counter SHALL count only on cycles with !aluBusy_i, and SHALL load 0 on entry to DRAIN.
REQ-035 halt_i SHALL be ignored outside RUN.
REQ-036 halted_o SHALL be 1 only in HALTED; in HALTED, F_stall_o = D_stall_o = 1 and E_flush_o = 1.
REQ-037 A mispredict in the halt cycle SHALL still flush D (D_flush_o = 1).
REQ-038 stallCycles_o SHALL increment on each cycle with D_stall_o, saturating at all-ones.
REQ-039 flushCount_o SHALL increment on each cycle with D_flush_o, saturating at all-ones.
REQ-040 Neither counter SHALL increment in HALTED.
REQ-041 All state SHALL be registered; outputs other than the counters and halted_o are combinational from inputs and state.

Reset
REQ-042 On reset_i=1 at a clock edge: scoreboard cleared, state = RUN, drain counter = 0, counters = 0, halted_o = 0.
REQ-043 Reset SHALL take effect mid-DRAIN or in HALTED.
REQ-044 With reset_i held and all inputs at 0, every output SHALL be 0.

Verification
REQ-045 Load-use: issue a load with rd=5 and D_longLat_i=1; next D reads rs1=5 -> dataHazard_o=1, F_stall_o=D_stall_o=1, E_flush_o=1 until MW_wbEnable_i with MW_rdId_i=5, then 0 in that same cycle.
REQ-046 Same-edge set and clear: issue rd=7 while MW clears 7 -> pend[7]=1 afterwards.
REQ-047 aluBusy_i=1 with E_correctPC_i=1 -> D_flush_o=0, E_stall_o=1, M_flush_o=1; after aluBusy_i drops, E_correctPC_i=1 -> D_flush_o=E_flush_o=1 and flushCount_o increments by 1.
REQ-048 halt_i pulse with DRAIN_CYCLES=3 and aluBusy_i high for 2 of the drain cycles -> halted_o rises after exactly 5 cycles; a halt_i pulse in HALTED has no effect.
REQ-049 Writes to rd=0 with D_longLat_i=1 -> no scoreboard bit set, and no hazard for a reader of rs=0.
REQ-050 Counter saturation with CNT_W=4: hold a stall for 20 cycles -> stallCycles_o=15; reset -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/halt controller: RAW scoreboard, stall/flush steering, drain-to-halt FSM, perf counters.
// Controls are combinational from inputs and state; scoreboard, FSM and counters update one edge later.
module pipe_hazard_ctrl #(
    parameter int REG_ID_W     = 6,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                halt_i,
    input  logic                aluBusy_i,
    input  logic                E_correctPC_i,
    input  logic                D_valid_i,
    input  logic [REG_ID_W-1:0] D_rs1Id_i,
    input  logic [REG_ID_W-1:0] D_rs2Id_i,
    input  logic [REG_ID_W-1:0] D_rs3Id_i,
    input  logic [2:0]          D_rsUse_i,
    input  logic [REG_ID_W-1:0] D_rdId_i,
    input  logic                D_wbEnable_i,
    input  logic                D_longLat_i,
    input  logic                MW_wbEnable_i,
    input  logic [REG_ID_W-1:0] MW_rdId_i,
    output logic                F_stall_o,
    output logic                D_stall_o,
    output logic                E_stall_o,
    output logic                D_flush_o,
    output logic                E_flush_o,
    output logic                M_flush_o,
    output logic                dataHazard_o,
    output logic                halted_o,
    output logic [CNT_W-1:0]    stallCycles_o,
    output logic [CNT_W-1:0]    flushCount_o
);

    localparam int NREG = 1 << REG_ID_W;
    localparam int DW   = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [NREG-1:0]     pend_q, pend_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic [REG_ID_W-1:0] rs_id [3];
    logic [2:0]          rs_hit;
    logic                in_run;
    logic                in_drain;
    logic                in_halted;
    logic                issue;

    assign rs_id[0] = D_rs1Id_i;
    assign rs_id[1] = D_rs2Id_i;
    assign rs_id[2] = D_rs3Id_i;

    assign in_run    = (state_q == ST_RUN);
    assign in_drain  = (state_q == ST_DRAIN);
    assign in_halted = (state_q == ST_HALTED);

    // A writeback landing this cycle satisfies the reader, so it bypasses the hazard.
    always_comb begin
        rs_hit = '0;
        for (int n = 0; n < 3; n++) begin
            rs_hit[n] = D_rsUse_i[n] & pend_q[rs_id[n]]
                      & !(MW_wbEnable_i && (MW_rdId_i == rs_id[n]));
        end
    end

    assign dataHazard_o = D_valid_i & (|rs_hit);
    assign D_flush_o    = E_correctPC_i & !aluBusy_i;
    assign E_stall_o    = aluBusy_i;
    assign M_flush_o    = aluBusy_i;

    // HALTED pins the front end regardless of any late mispredict.
    assign F_stall_o = ((dataHazard_o | aluBusy_i | !in_run) & !D_flush_o) | in_halted;
    assign D_stall_o = F_stall_o;
    assign E_flush_o = (!aluBusy_i & (D_flush_o | dataHazard_o | in_drain)) | in_halted;
    assign halted_o  = in_halted;

    assign issue = D_valid_i & D_wbEnable_i & D_longLat_i & (D_rdId_i != '0)
                 & !D_stall_o & !D_flush_o & in_run;

    // Clear first so that a same-edge set on the same id wins.
    always_comb begin
        pend_d = pend_q;
        if (MW_wbEnable_i) begin
            pend_d[MW_rdId_i] = 1'b0;
        end
        if (issue) begin
            pend_d[D_rdId_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (halt_i) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (!aluBusy_i) begin
                    if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DW'(1);
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!in_halted) begin
            if (D_stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (D_flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stallCycles_o = stall_cnt_q;
    assign flushCount_o  = flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            pend_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with CNT_W=4 so counter saturation is reachable.
// Control outputs are packed {F_stall,D_stall,E_stall,D_flush,E_flush,M_flush,hazard,halted}.
module tb_pipe_hazard_ctrl;

    localparam int RW = 6;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          halt_i, aluBusy_i, E_correctPC_i, D_valid_i;
    logic [RW-1:0] D_rs1Id_i, D_rs2Id_i, D_rs3Id_i, D_rdId_i, MW_rdId_i;
    logic [2:0]    D_rsUse_i;
    logic          D_wbEnable_i, D_longLat_i, MW_wbEnable_i;
    logic          F_stall_o, D_stall_o, E_stall_o, D_flush_o, E_flush_o, M_flush_o;
    logic          dataHazard_o, halted_o;
    logic [CW-1:0] stallCycles_o, flushCount_o;
    logic [7:0]    ctl;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.REG_ID_W(RW), .DRAIN_CYCLES(3), .CNT_W(CW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .halt_i(halt_i), .aluBusy_i(aluBusy_i),
        .E_correctPC_i(E_correctPC_i), .D_valid_i(D_valid_i),
        .D_rs1Id_i(D_rs1Id_i), .D_rs2Id_i(D_rs2Id_i), .D_rs3Id_i(D_rs3Id_i),
        .D_rsUse_i(D_rsUse_i), .D_rdId_i(D_rdId_i), .D_wbEnable_i(D_wbEnable_i),
        .D_longLat_i(D_longLat_i), .MW_wbEnable_i(MW_wbEnable_i), .MW_rdId_i(MW_rdId_i),
        .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .E_stall_o(E_stall_o),
        .D_flush_o(D_flush_o), .E_flush_o(E_flush_o), .M_flush_o(M_flush_o),
        .dataHazard_o(dataHazard_o), .halted_o(halted_o),
        .stallCycles_o(stallCycles_o), .flushCount_o(flushCount_o)
    );

    always #5 clk_i = ~clk_i;

    assign ctl = {F_stall_o, D_stall_o, E_stall_o, D_flush_o,
                  E_flush_o, M_flush_o, dataHazard_o, halted_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        halt_i = 0; aluBusy_i = 0; E_correctPC_i = 0; D_valid_i = 0;
        D_rs1Id_i = 0; D_rs2Id_i = 0; D_rs3Id_i = 0; D_rsUse_i = 0; D_rdId_i = 0;
        D_wbEnable_i = 0; D_longLat_i = 0; MW_wbEnable_i = 0; MW_rdId_i = 0;
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic reader(input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                          input logic [RW-1:0] r3, input logic [2:0] use_v);
        D_valid_i = 1; D_rs1Id_i = r1; D_rs2Id_i = r2; D_rs3Id_i = r3; D_rsUse_i = use_v;
    endtask

    task automatic writer(input logic [RW-1:0] rd, input logic long_lat);
        D_valid_i = 1; D_wbEnable_i = 1; D_longLat_i = long_lat; D_rdId_i = rd;
    endtask

    initial begin
        reset_i = 1;
        idle();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ctl", 32'(ctl), 32'h00);
        chk("rst_stall_cnt", 32'(stallCycles_o), 0);
        chk("rst_flush_cnt", 32'(flushCount_o), 0);

        // load-use on x5
        nxt(); reset_i = 0; writer(6'd5, 1);
        @(negedge clk_i); chk("ld_issue_ctl", 32'(ctl), 32'h00);
        for (int i = 0; i < 2; i++) begin
            nxt(); reader(6'd5, 6'd0, 6'd0, 3'b001);
            @(negedge clk_i); chk("ld_use_ctl", 32'(ctl), 32'hCA);
        end
        nxt(); reader(6'd5, 6'd0, 6'd0, 3'b001); MW_wbEnable_i = 1; MW_rdId_i = 6'd5;
        @(negedge clk_i); chk("ld_bypass_ctl", 32'(ctl), 32'h00);
        chk("ld_stall_cnt", 32'(stallCycles_o), 2);
        nxt(); reader(6'd5, 6'd0, 6'd0, 3'b001);
        @(negedge clk_i); chk("ld_cleared_ctl", 32'(ctl), 32'h00);

        // same-edge set and clear on x7: set wins
        nxt(); writer(6'd7, 1); MW_wbEnable_i = 1; MW_rdId_i = 6'd7;
        @(negedge clk_i); chk("se_issue_ctl", 32'(ctl), 32'h00);
        nxt(); reader(6'd7, 6'd7, 6'd8, 3'b100);
        @(negedge clk_i); chk("se_unused_rs_ctl", 32'(ctl), 32'h00);
        nxt(); reader(6'd0, 6'd7, 6'd0, 3'b010);
        @(negedge clk_i); chk("se_pend7_ctl", 32'(ctl), 32'hCA);
        nxt(); reader(6'd0, 6'd7, 6'd0, 3'b010); MW_wbEnable_i = 1; MW_rdId_i = 6'd7;
        @(negedge clk_i); chk("se_bypass_ctl", 32'(ctl), 32'h00);
        nxt(); reader(6'd0, 6'd7, 6'd0, 3'b010);
        @(negedge clk_i); chk("se_cleared_ctl", 32'(ctl), 32'h00);

        // rd=0 and short-latency writers never mark pending
        nxt(); writer(6'd0, 1);
        nxt(); reader(6'd0, 6'd0, 6'd0, 3'b111);
        @(negedge clk_i); chk("x0_no_hazard", 32'(ctl), 32'h00);
        nxt(); writer(6'd9, 0);
        nxt(); reader(6'd9, 6'd0, 6'd0, 3'b001);
        @(negedge clk_i); chk("short_lat_no_hazard", 32'(ctl), 32'h00);

        // mispredict masked by busy ALU, then honoured
        nxt(); aluBusy_i = 1; E_correctPC_i = 1;
        @(negedge clk_i); chk("busy_mispred_ctl", 32'(ctl), 32'hE4);
        nxt(); E_correctPC_i = 1;
        @(negedge clk_i); chk("mispred_ctl", 32'(ctl), 32'h18);
        chk("mispred_flush_before", 32'(flushCount_o), 0);
        nxt();
        @(negedge clk_i); chk("mispred_flush_after", 32'(flushCount_o), 1);
        chk("busy_stall_cnt", 32'(stallCycles_o), 4);

        // halt with a mispredict in the same cycle, then drain with 2 busy cycles
        nxt(); halt_i = 1; E_correctPC_i = 1;
        @(negedge clk_i); chk("halt_mispred_ctl", 32'(ctl), 32'h18);
        for (int c = 1; c <= 5; c++) begin
            nxt(); aluBusy_i = (c == 2 || c == 4);
            @(negedge clk_i);
            chk($sformatf("drain%0d_ctl", c), 32'(ctl), (c == 2 || c == 4) ? 32'hE4 : 32'hC8);
        end
        nxt();
        @(negedge clk_i); chk("halted_ctl", 32'(ctl), 32'hC9);
        chk("halted_stall_cnt", 32'(stallCycles_o), 9);
        chk("halted_flush_cnt", 32'(flushCount_o), 2);
        nxt(); halt_i = 1; E_correctPC_i = 1;
        @(negedge clk_i); chk("halted_mispred_ctl", 32'(ctl), 32'hD9);
        nxt();
        @(negedge clk_i); chk("halted_sticky_ctl", 32'(ctl), 32'hC9);
        chk("halted_stall_frozen", 32'(stallCycles_o), 9);
        chk("halted_flush_frozen", 32'(flushCount_o), 2);

        // reset out of HALTED, then again mid-DRAIN
        nxt(); reset_i = 1;
        nxt(); reset_i = 0;
        @(negedge clk_i); chk("post_halt_rst_ctl", 32'(ctl), 32'h00);
        chk("post_halt_rst_flush", 32'(flushCount_o), 0);
        nxt(); halt_i = 1;
        nxt(); reset_i = 1;
        @(negedge clk_i); chk("mid_drain_ctl", 32'(ctl), 32'hC8);
        nxt(); reset_i = 0;
        @(negedge clk_i); chk("mid_drain_rst_ctl", 32'(ctl), 32'h00);
        chk("mid_drain_rst_stall", 32'(stallCycles_o), 0);

        // saturation of the 4-bit stall counter
        for (int i = 0; i < 20; i++) begin
            nxt(); aluBusy_i = 1;
        end
        nxt();
        @(negedge clk_i); chk("stall_saturated", 32'(stallCycles_o), 15);
        nxt(); reset_i = 1;
        nxt(); reset_i = 0;
        @(negedge clk_i); chk("stall_after_rst", 32'(stallCycles_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
